// File: rtl/dbus_arb_if.sv
// rtl/dbus_arb_if.sv - master-side and slave-side bus interfaces for dbus_arb

interface dbus_arb_if #(
   parameter int DW = 16,
   parameter int AW = 16
);
   logic          req;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic          gnt;
   logic          rvld;
   logic [DW-1:0] dout;

   modport master (output req, we, addr, din, input gnt, rvld, dout);
   modport slave  (input req, we, addr, din, output gnt, rvld, dout);
endinterface

interface dbus_slv_if #(
   parameter int DW = 16,
   parameter int AW = 16
);
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic          we;
   logic [DW-1:0] dout;

   modport master (output addr, din, we, input dout);
   modport slave  (input addr, din, we, output dout);
endinterface

// File: rtl/dbus_arb.sv
// rtl/dbus_arb.sv - two-master data bus arbiter, fixed priority with starvation counter
// (round-robin when DBUS_ARB_RR_EN is defined)

module dbus_arb #(
   parameter int DW       = 16,
   parameter int AW       = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   dbus_arb_if.slave   m0,
   dbus_arb_if.slave   m1,
   dbus_slv_if.master  s
);
   logic pick0;
   logic g0;
   logic g1;
   logic rpend;
   logic rsel;
   logic rv0;
   logic rv1;

`ifdef DBUS_ARB_RR_EN
   // Set when m0 holds the most recent grant; reset 0 lets m0 win the first tie.
   logic last;

   always_comb begin
      pick0 = m0.req && (!m1.req || !last);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last <= 1'b0;
      else if (g0)
         last <= 1'b1;
      else if (g1)
         last <= 1'b0;
   end
`else
   localparam logic [3:0] MW = 4'(MAX_WAIT);
   logic [3:0] cnt;

   always_comb begin
      pick0 = m0.req && !(m1.req && (cnt == MW));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= 4'd0;
      else if (g1 || !m1.req)
         cnt <= 4'd0;
      else if (g0 && (cnt != MW))
         cnt <= cnt + 4'd1;
   end
`endif

   always_comb begin
      g0 = rst_n && pick0;
      g1 = rst_n && m1.req && !pick0;
   end

   always_comb begin
      s.we   = 1'b0;
      s.addr = '0;
      s.din  = '0;
      if (g0) begin
         s.we   = m0.we;
         s.addr = m0.addr;
         s.din  = m0.din;
      end else if (g1) begin
         s.we   = m1.we;
         s.addr = m1.addr;
         s.din  = m1.din;
      end
   end

   // Slave read path is registered, so the read owner is remembered for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpend <= 1'b0;
         rsel  <= 1'b0;
      end else begin
         rpend <= (g0 && !m0.we) || (g1 && !m1.we);
         if (g0 || g1)
            rsel <= g1;
      end
   end

   always_comb begin
      rv0 = rpend && !rsel;
      rv1 = rpend && rsel;
   end

   assign m0.gnt  = g0;
   assign m1.gnt  = g1;
   assign m0.rvld = rv0;
   assign m1.rvld = rv1;
   assign m0.dout = rv0 ? s.dout : '0;
   assign m1.dout = rv1 ? s.dout : '0;

endmodule

// File: tb/tb_dbus_arb.sv
// tb/tb_dbus_arb.sv - table-driven self-checking bench for dbus_arb (fixed-priority build)

module tb_dbus_arb;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   dbus_arb_if #(.DW(16), .AW(16)) m0_bus ();
   dbus_arb_if #(.DW(16), .AW(16)) m1_bus ();
   dbus_slv_if #(.DW(16), .AW(16)) s_bus ();

   dbus_arb #(.DW(16), .AW(16), .MAX_WAIT(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .m0    (m0_bus.slave),
      .m1    (m1_bus.slave),
      .s     (s_bus.master)
   );

   always #5 clk = ~clk;

   // Registered 16-word slave memory, cleared to D000|index while in reset.
   logic [15:0] mem [16];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'hD000 | 16'(i);
         s_bus.dout <= 16'h0000;
      end else begin
         if (s_bus.we) mem[s_bus.addr[3:0]] <= s_bus.din;
         s_bus.dout <= mem[s_bus.addr[3:0]];
      end
   end

   typedef struct {
      logic        m0r, m0w;
      logic [15:0] m0a, m0d;
      logic        m1r, m1w;
      logic [15:0] m1a, m1d;
      logic        g0, g1, swe;
      logic [15:0] saddr, sdin;
      logic        rv0;
      logic [15:0] d0;
      logic        rv1;
      logic [15:0] d1;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic m0r, logic m0w, logic [15:0] m0a, logic [15:0] m0d,
                               logic m1r, logic m1w, logic [15:0] m1a, logic [15:0] m1d,
                               logic g0, logic g1, logic swe, logic [15:0] saddr, logic [15:0] sdin,
                               logic rv0, logic [15:0] d0, logic rv1, logic [15:0] d1);
      vec_t v;
      v.m0r = m0r; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d;
      v.m1r = m1r; v.m1w = m1w; v.m1a = m1a; v.m1d = m1d;
      v.g0 = g0; v.g1 = g1; v.swe = swe; v.saddr = saddr; v.sdin = sdin;
      v.rv0 = rv0; v.d0 = d0; v.rv1 = rv1; v.d1 = d1;
      tbl.push_back(v);
   endfunction

   task automatic chk(string name, int row, logic [15:0] act, logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
      end
   endtask

   task automatic drive(logic m0r, logic m0w, logic [15:0] m0a, logic [15:0] m0d,
                        logic m1r, logic m1w, logic [15:0] m1a, logic [15:0] m1d);
      m0_bus.req = m0r; m0_bus.we = m0w; m0_bus.addr = m0a; m0_bus.din = m0d;
      m1_bus.req = m1r; m1_bus.we = m1w; m1_bus.addr = m1a; m1_bus.din = m1d;
   endtask

   task automatic chk_grants(string tag, int row, logic g0, logic g1);
      chk({tag, "_g0"}, row, 16'(m0_bus.gnt), 16'(g0));
      chk({tag, "_g1"}, row, 16'(m1_bus.gnt), 16'(g1));
   endtask

   task automatic chk_quiet(string tag, int row);
      chk({tag, "_rv0"}, row, 16'(m0_bus.rvld), 16'h0);
      chk({tag, "_rv1"}, row, 16'(m1_bus.rvld), 16'h0);
      chk({tag, "_d0"}, row, m0_bus.dout, 16'h0);
      chk({tag, "_d1"}, row, m1_bus.dout, 16'h0);
   endtask

   initial begin
      // Write then read from m0 alone.
      add(1,1,16'h1004,16'hA5A5, 0,0,16'h0,16'h0, 1,0, 1,16'h1004,16'hA5A5, 0,16'h0, 0,16'h0);
      add(1,0,16'h1004,16'h0000, 0,0,16'h0,16'h0, 1,0, 0,16'h1004,16'h0000, 0,16'h0, 0,16'h0);
      add(0,0,16'h0,16'h0,       0,0,16'h0,16'h0, 0,0, 0,16'h0000,16'h0000, 1,16'hA5A5, 0,16'h0);
      // Both read continuously: m0 x4 then m1.
      add(1,0,16'h0001,16'h0, 1,0,16'h0002,16'h0, 1,0, 0,16'h0001,16'h0, 0,16'h0, 0,16'h0);
      for (int i = 0; i < 3; i++)
         add(1,0,16'h0001,16'h0, 1,0,16'h0002,16'h0, 1,0, 0,16'h0001,16'h0, 1,16'hD001, 0,16'h0);
      add(1,0,16'h0001,16'h0, 1,0,16'h0002,16'h0, 0,1, 0,16'h0002,16'h0, 1,16'hD001, 0,16'h0);
      add(1,0,16'h0001,16'h0, 1,0,16'h0002,16'h0, 1,0, 0,16'h0001,16'h0, 0,16'h0, 1,16'hD002);
      for (int i = 0; i < 3; i++)
         add(1,0,16'h0001,16'h0, 1,0,16'h0002,16'h0, 1,0, 0,16'h0001,16'h0, 1,16'hD001, 0,16'h0);
      add(1,0,16'h0001,16'h0, 1,0,16'h0002,16'h0, 0,1, 0,16'h0002,16'h0, 1,16'hD001, 0,16'h0);
      // m1 read, then m0 write while m1 read data returns.
      add(0,0,16'h0,16'h0, 1,0,16'h0003,16'h0, 0,1, 0,16'h0003,16'h0, 0,16'h0, 1,16'hD002);
      add(1,1,16'h0005,16'h1234, 0,0,16'h0,16'h0, 1,0, 1,16'h0005,16'h1234, 0,16'h0, 1,16'hD003);
      add(1,0,16'h0005,16'h0, 0,0,16'h0,16'h0, 1,0, 0,16'h0005,16'h0, 0,16'h0, 0,16'h0);
      add(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,16'h0,16'h0, 1,16'h1234, 0,16'h0);
      // Contending writes, then reads back from both.
      add(1,1,16'h0008,16'hCAFE, 1,1,16'h0007,16'hBEEF, 1,0, 1,16'h0008,16'hCAFE, 0,16'h0, 0,16'h0);
      add(0,0,16'h0,16'h0, 1,1,16'h0007,16'hBEEF, 0,1, 1,16'h0007,16'hBEEF, 0,16'h0, 0,16'h0);
      add(1,0,16'h0008,16'h0, 1,0,16'h0007,16'h0, 1,0, 0,16'h0008,16'h0, 0,16'h0, 0,16'h0);
      add(0,0,16'h0,16'h0, 1,0,16'h0007,16'h0, 0,1, 0,16'h0007,16'h0, 1,16'hCAFE, 0,16'h0);
      add(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,16'h0,16'h0, 0,16'h0, 1,16'hBEEF);
      // Counter clears when m1 drops req mid-count.
      add(1,0,16'h0009,16'h0, 1,0,16'h000A,16'h0, 1,0, 0,16'h0009,16'h0, 0,16'h0, 0,16'h0);
      add(1,0,16'h0009,16'h0, 1,0,16'h000A,16'h0, 1,0, 0,16'h0009,16'h0, 1,16'hD009, 0,16'h0);
      add(1,0,16'h0009,16'h0, 1,0,16'h000A,16'h0, 1,0, 0,16'h0009,16'h0, 1,16'hD009, 0,16'h0);
      add(1,0,16'h0009,16'h0, 0,0,16'h0,16'h0,    1,0, 0,16'h0009,16'h0, 1,16'hD009, 0,16'h0);
      for (int i = 0; i < 4; i++)
         add(1,0,16'h0009,16'h0, 1,0,16'h000A,16'h0, 1,0, 0,16'h0009,16'h0, 1,16'hD009, 0,16'h0);
      add(1,0,16'h0009,16'h0, 1,0,16'h000A,16'h0, 0,1, 0,16'h000A,16'h0, 1,16'hD009, 0,16'h0);
      add(0,0,16'h0,16'h0, 0,0,16'h0,16'h0, 0,0, 0,16'h0,16'h0, 0,16'h0, 1,16'hD00A);

      // Reset state: requests high while in reset must not be granted.
      drive(1,1,16'h1111,16'h2222, 1,1,16'h3333,16'h4444);
      #2;
      chk_grants("rst", -1, 1'b0, 1'b0);
      chk("rst_swe", -1, 16'(s_bus.we), 16'h0);
      chk("rst_saddr", -1, s_bus.addr, 16'h0);
      chk_quiet("rst", -1);
      @(negedge clk);
      @(negedge clk);
      drive(0,0,16'h0,16'h0, 0,0,16'h0,16'h0);
      rst_n = 1'b1;

      foreach (tbl[k]) begin
         @(negedge clk);
         drive(tbl[k].m0r, tbl[k].m0w, tbl[k].m0a, tbl[k].m0d,
               tbl[k].m1r, tbl[k].m1w, tbl[k].m1a, tbl[k].m1d);
         #1;
         chk_grants("vec", k, tbl[k].g0, tbl[k].g1);
         chk("vec_swe", k, 16'(s_bus.we), 16'(tbl[k].swe));
         chk("vec_saddr", k, s_bus.addr, tbl[k].saddr);
         chk("vec_sdin", k, s_bus.din, tbl[k].sdin);
         chk("vec_rv0", k, 16'(m0_bus.rvld), 16'(tbl[k].rv0));
         chk("vec_d0", k, m0_bus.dout, tbl[k].d0);
         chk("vec_rv1", k, 16'(m1_bus.rvld), 16'(tbl[k].rv1));
         chk("vec_d1", k, m1_bus.dout, tbl[k].d1);
      end

      // Idle bus for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(0,0,16'h0,16'h0, 0,0,16'h0,16'h0);
         #1;
         chk_grants("idle", i, 1'b0, 1'b0);
         chk("idle_swe", i, 16'(s_bus.we), 16'h0);
         chk("idle_saddr", i, s_bus.addr, 16'h0);
         chk("idle_sdin", i, s_bus.din, 16'h0);
         chk_quiet("idle", i);
      end

      // Build up cnt=3 with a granted m0 read, then reset mid-operation.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(1,0,16'h0001,16'h0, 1,0,16'h0002,16'h0);
         #1;
         chk_grants("pre", i, 1'b1, 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_grants("midrst", 0, 1'b0, 1'b0);
      chk_quiet("midrst", 0);
      @(negedge clk);
      #1;
      chk_grants("midrst", 1, 1'b0, 1'b0);
      chk_quiet("midrst", 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk_quiet("post", 0);
      // cnt restarted at 0: four m0 grants before m1.
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            @(negedge clk);
            #1;
         end
         chk_grants("post", i, i < 4, i == 4);
      end

      @(negedge clk);
      drive(0,0,16'h0,16'h0, 0,0,16'h0,16'h0);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
